// File: rtl/pkmc_sdram_arbiter.sv
// Two-master SDRAM access arbiter with an auto-refresh scheduler. Round-robin tie-break;
// define PKMC_ARB_FIXED_PRIO_EN to give master 1 fixed priority on a tie instead.
module pkmc_sdram_arbiter #(
  parameter int REFRESH_CYCLES = 390,
  parameter int CNT_W          = 9
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       init_done_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       we0_i,
  input  logic       we1_i,
  input  logic       ctrl_done_i,
  output logic       ctrl_req_o,
  output logic       ctrl_we_o,
  output logic       refr_req_o,
  output logic [1:0] gnt_o,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       refr_ovf_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REFRESH} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_pend;
  logic             r_ovf;
  logic [1:0]       r_gnt, w_gnt_nxt;
  logic             r_creq, w_creq_nxt;
  logic             r_we, w_we_nxt;
  logic             r_refr, w_refr_nxt;
  logic             w_ack0, w_ack1, w_dec, w_tick, w_sel;

  assign w_tick = init_done_i && (r_cnt == '0);

`ifdef PKMC_ARB_FIXED_PRIO_EN
  assign w_sel = req1_i;
`else
  logic r_last;

  // On a tie the master not served last wins; r_last = 1 means m1 was served last.
  assign w_sel = (req0_i && req1_i) ? ~r_last : req1_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_last <= 1'b1;
    else if (r_state == S_IDLE && w_state_nxt == S_BUSY)
      r_last <= w_sel;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_cnt <= RELOAD;
    else if (!init_done_i || r_cnt == '0)
      r_cnt <= RELOAD;
    else
      r_cnt <= r_cnt - 1'b1;
  end

  // A tick coinciding with a completed refresh cancels out; a tick at 3 is lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend <= 2'd0;
      r_ovf  <= 1'b0;
    end else if (!init_done_i) begin
      r_pend <= 2'd0;
    end else if (w_tick && !w_dec) begin
      if (r_pend == 2'd3)
        r_ovf <= 1'b1;
      else
        r_pend <= r_pend + 2'd1;
    end else if (!w_tick && w_dec) begin
      r_pend <= r_pend - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_creq  <= 1'b0;
      r_we    <= 1'b0;
      r_refr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_creq  <= w_creq_nxt;
      r_we    <= w_we_nxt;
      r_refr  <= w_refr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_creq_nxt  = r_creq;
    w_we_nxt    = r_we;
    w_refr_nxt  = r_refr;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_dec       = 1'b0;
    if (!init_done_i) begin
      w_state_nxt = S_IDLE;
      w_gnt_nxt   = 2'b00;
      w_creq_nxt  = 1'b0;
      w_we_nxt    = 1'b0;
      w_refr_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend != 2'd0) begin
            w_state_nxt = S_REFRESH;
            w_refr_nxt  = 1'b1;
          end else if (req0_i || req1_i) begin
            w_state_nxt = S_BUSY;
            w_gnt_nxt   = w_sel ? 2'b10 : 2'b01;
            w_creq_nxt  = 1'b1;
            w_we_nxt    = w_sel ? we1_i : we0_i;
          end
        end
        S_BUSY: begin
          if (ctrl_done_i) begin
            w_ack0      = r_gnt[0];
            w_ack1      = r_gnt[1];
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 2'b00;
            w_creq_nxt  = 1'b0;
            w_we_nxt    = 1'b0;
          end
        end
        S_REFRESH: begin
          if (ctrl_done_i) begin
            w_state_nxt = S_IDLE;
            w_refr_nxt  = 1'b0;
            w_dec       = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign ctrl_req_o = r_creq;
  assign ctrl_we_o  = r_we;
  assign refr_req_o = r_refr;
  assign ack0_o     = w_ack0;
  assign ack1_o     = w_ack1;
  assign refr_ovf_o = r_ovf;

endmodule

// File: tb/tb_pkmc_sdram_arbiter.sv
// Bench for pkmc_sdram_arbiter: vector table, corner-case sequences, and random traffic
// checked against a cycle-level transaction model.
module tb_pkmc_sdram_arbiter;
  localparam int N = 8;
`ifdef PKMC_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, init = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, done = 1'b0;
  logic creq, cwe, refr, ack0, ack1, ovf;
  logic [1:0] gnt;
  logic [7:0] w_outs;
  int total = 0, bad = 0;

  pkmc_sdram_arbiter #(.REFRESH_CYCLES(N), .CNT_W(9)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_done_i(init),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .ctrl_done_i(done), .ctrl_req_o(creq), .ctrl_we_o(cwe), .refr_req_o(refr),
    .gnt_o(gnt), .ack0_o(ack0), .ack1_o(ack1), .refr_ovf_o(ovf)
  );

  always #5 clk = ~clk;
  assign w_outs = {gnt, creq, cwe, refr, ack0, ack1, ovf};

  typedef struct {
    logic init, r0, r1, w0, w1, d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[16];

  // Reference model: mode 0 idle, 1 access, 2 refresh.
  int m_mode, m_owner, m_pend, m_last, m_run;
  logic m_we, m_ovf;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b (gnt,creq,cwe,refr,ack0,ack1,ovf)", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic i, r0, r1, w0, w1, d, input logic [7:0] e);
    vec_t v;
    v.init = i; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.d = d; v.exp = e;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_pend = 0; m_last = 1; m_run = 0; m_we = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int np, tick, dec, w;
    if (!init) begin
      m_mode = 0; m_pend = 0; m_run = 0;
      return;
    end
    m_run++;
    tick = (m_run % N == 0) ? 1 : 0;
    dec  = (m_mode == 2 && done) ? 1 : 0;
    if (m_mode == 0) begin
      if (m_pend > 0) m_mode = 2;
      else if (req0 || req1) begin
        if (req0 && req1) w = FIXED ? 1 : 1 - m_last;
        else w = req1 ? 1 : 0;
        m_owner = w; m_we = w ? we1 : we0; m_last = w; m_mode = 1;
      end
    end else if (done) m_mode = 0;
    np = m_pend + tick - dec;
    if (np > 3) begin m_ovf = 1'b1; np = 3; end
    m_pend = np;
  endtask

  function automatic logic [7:0] model_exp();
    logic b;
    logic [1:0] g;
    b = (m_mode == 1);
    g = b ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    return {g, b, b & m_we, (m_mode == 2), b & done & init & (m_owner == 0),
            b & done & init & (m_owner == 1), m_ovf};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; init = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, refs;
    logic a0, a1;
    int dprob;
    bit FX, NF, weW, weL, lr0, lr1;
    logic [1:0] gW, gL;
    FX = FIXED; NF = !FIXED;
    gW = FIXED ? 2'b10 : 2'b01;  gL = FIXED ? 2'b01 : 2'b10;
    weW = FIXED;  weL = !FIXED;   lr0 = FIXED;  lr1 = !FIXED;

    tbl[0]  = mk(1, 1, 0, 1, 0, 0, 8'b0);
    tbl[1]  = mk(1, 1, 0, 1, 0, 0, {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl[2]  = mk(1, 1, 0, 1, 0, 1, {2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 8'b0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 1, {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl[5]  = mk(1, 1, 1, 0, 1, 0, 8'b0);
    tbl[6]  = mk(1, 1, 1, 0, 1, 1, {gW, 1'b1, weW, 1'b0, NF, FX, 1'b0});
    tbl[7]  = mk(1, lr0, lr1, 0, 1, 0, 8'b0);
    tbl[8]  = mk(1, lr0, lr1, 0, 1, 0, {gL, 1'b1, weL, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl[9]  = mk(1, lr0, lr1, 0, 1, 1, {gL, 1'b1, weL, 1'b0, FX, NF, 1'b0});
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 8'b0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl[12] = mk(1, 0, 0, 0, 0, 1, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 8'b0);
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 8'b0);
    tbl[15] = mk(1, 1, 0, 1, 0, 0, {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_state", w_outs, 8'b0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      init = tbl[i].init; req0 = tbl[i].r0; req1 = tbl[i].r1;
      we0 = tbl[i].w0; we1 = tbl[i].w1; done = tbl[i].d;
      @(negedge clk);
      check($sformatf("vec%0d", i), w_outs, tbl[i].exp);
    end

    // Refresh cadence with no traffic
    do_reset();
    @(posedge clk);
    #1 init = 1'b1;
    n = 0;
    while (n < 20 && !refr) begin @(posedge clk); n++; #1; end
    check_int("refr_first_latency", n, 9);
    done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    check_int("refr_drop_after_done", int'(refr), 0);
    m = 1;
    while (m < 20 && !refr) begin @(posedge clk); m++; #1; end
    check_int("refr_period", m, 8);

    // Long access: pending saturates, then queued refreshes drain before the next grant
    do_reset();
    @(posedge clk);
    #1 init = 1'b1; req0 = 1'b1; we0 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("long_busy_gnt", {6'b0, gnt}, 8'b01);
    check_int("ovf_set", int'(ovf), 1);
    done = 1'b1; req1 = 1'b1; we1 = 1'b1;
    @(negedge clk);
    check_int("long_busy_ack0", int'(ack0), 1);
    @(posedge clk);
    #1 done = 1'b0; req0 = 1'b0;
    n = 0; refs = 0;
    while (n < 30 && gnt == 2'b00) begin
      if (refr) begin refs++; done = 1'b1; end else done = 1'b0;
      @(posedge clk);
      n++;
      #1;
    end
    done = 1'b0;
    check_int("drain_refreshes", refs, 3);
    check("drain_then_gnt", {6'b0, gnt}, 8'b10);
    check_int("ovf_sticky", int'(ovf), 1);

    // init_done drop mid-access, then async reset mid-refresh
    do_reset();
    @(posedge clk);
    #1 init = 1'b1; req0 = 1'b1; we0 = 1'b1;
    @(posedge clk);
    #1 check("abort_busy_before", w_outs, {2'b01, 1'b1, 1'b1, 4'b0});
    init = 1'b0; done = 1'b1;
    @(negedge clk);
    check_int("abort_no_ack", int'(ack0), 0);
    @(posedge clk);
    #1 done = 1'b0; req0 = 1'b0;
    check("abort_outputs_zero", w_outs, 8'b0);
    init = 1'b1;
    n = 0;
    while (n < 20 && !refr) begin @(posedge clk); n++; #1; end
    check_int("refr_after_reinit", n, 9);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_refresh", w_outs, 8'b0);

    // Random traffic against the model
    do_reset();
    #1 init = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      dprob = (c < 1500) ? 2 : 19;
      @(posedge clk);
      a0 = (m_mode == 1) && done && init && (m_owner == 0);
      a1 = (m_mode == 1) && done && init && (m_owner == 1);
      model_edge();
      #1;
      if (a0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3) == 0) begin req0 = 1'b1; we0 = 1'($urandom_range(1)); end
      if (a1) req1 = 1'b0;
      else if (!req1 && $urandom_range(3) == 0) begin req1 = 1'b1; we1 = 1'($urandom_range(1)); end
      done = ($urandom_range(dprob) == 0);
      if (init) begin
        if ($urandom_range(299) == 0) init = 1'b0;
      end else if ($urandom_range(3) == 0) init = 1'b1;
      @(negedge clk);
      check($sformatf("rand_cyc%0d", c), w_outs, model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkmc_sdram_arbiter.md
PKMC_SDRAM_ARBITER -- requirements
Module: pkmc_sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 390, meaning clocks between auto-refresh ticks (7.8 us at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 9, meaning refresh counter width; REFRESH_CYCLES-1 SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port init_done_i  input  1  SDRAM init sequence complete (level).
REQ-006 SHALL have ports req0_i / req1_i  input  1  master 0 (CPU) / master 1 (DMA) access request, level, held until ack.
REQ-007 SHALL have ports we0_i / we1_i  input  1  write enable of the matching master, valid while its req is high.
REQ-008 SHALL have port ctrl_done_i  input  1  one-cycle pulse from the SDRAM command FSM: current access or refresh finished.
REQ-009 SHALL have port ctrl_req_o  output  1  access request to the SDRAM command FSM.
REQ-010 SHALL have port ctrl_we_o  output  1  write/read of the granted access.
REQ-011 SHALL have port refr_req_o  output  1  auto-refresh request to the SDRAM command FSM.
REQ-012 SHALL have port gnt_o  output  2  one-hot owner of the access (bit0 = m0, bit1 = m1); 2'b00 when none.
REQ-013 SHALL have ports ack0_o / ack1_o  output  1  one-cycle completion pulse to the matching master.
REQ-014 SHALL have port refr_ovf_o  output  1  sticky flag: a refresh tick was lost.

Function
REQ-015 SHALL implement states IDLE, BUSY, REFRESH.
REQ-016 IDLE: init_done_i low -> stay in IDLE; else pending refresh > 0 -> REFRESH; else any req -> BUSY with the selected master; else stay.
REQ-017 Refresh SHALL win over pending requests in IDLE; it SHALL never preempt an access in BUSY.
REQ-018 Master selection SHALL be round-robin: when both request, the master not granted last wins; last-granted resets to m1, so m0 wins the first tie.
REQ-019 BUSY: gnt_o, ctrl_req_o and ctrl_we_o (we of owner, latched at grant) SHALL be registered outputs, stable for the whole state, asserted the cycle after the request is sampled in IDLE.
REQ-020 BUSY: ctrl_done_i high -> ack of owner SHALL be asserted combinationally in the same cycle, next state IDLE, gnt_o cleared; the master drops req at that edge.
REQ-021 REFRESH: refr_req_o high until ctrl_done_i; on done, pending decrements, next state IDLE.
REQ-022 ctrl_done_i in IDLE SHALL be ignored.
REQ-023 Refresh counter SHALL run only while init_done_i is high, count down from REFRESH_CYCLES-1, and on reaching 0 reload and issue a tick.
REQ-024 Pending refresh count SHALL be 2 bits, saturating at 3; a tick at 3 SHALL set refr_ovf_o and be lost.
REQ-025 Tick and refresh done in the same cycle SHALL leave the pending count unchanged.
REQ-026 init_done_i falling in any state SHALL abort to IDLE, clear gnt_o/ctrl_req_o/refr_req_o and pending, and reload the counter; no ack issued.

Reset
REQ-027 rst_n_i low SHALL immediately force IDLE, counter = REFRESH_CYCLES-1, pending = 0, last-granted = m1, and all outputs 0 including refr_ovf_o.
REQ-028 Reset mid-access SHALL drop the access with no ack.

Configuration
REQ-029 Macro PKMC_ARB_FIXED_PRIO_EN defined: master 1 SHALL always win a tie and last-granted is unused; undefined: round-robin per REQ-018.

Verification
REQ-030 Reset, init_done_i=1, req0_i=1 held -> ctrl_req_o=1, gnt_o=01 one cycle later; done pulse -> ack0_o=1 same cycle, gnt_o=00 next cycle.
REQ-031 req0_i and req1_i both high continuously -> grants alternate m0, m1, m0, m1 (with macro: m1 every time).
REQ-032 REFRESH_CYCLES=8, no requests -> refr_req_o rises 9 cycles after init_done_i (8 count cycles + 1 state cycle), every 8 cycles with prompt done.
REQ-033 REFRESH_CYCLES=8, ctrl_done_i withheld 40 cycles in BUSY -> pending saturates at 3, refr_ovf_o=1, then 3 refreshes back-to-back before the next grant.
REQ-034 init_done_i dropped in BUSY -> next cycle IDLE, all outputs 0, no ack; rst_n_i pulsed mid-REFRESH -> outputs 0 immediately without waiting for a clock edge.
